// File: rtl/comparator_cascade.sv
// Byte-serial equality compare that drives an external 74x688. Each cycle one
// byte pair goes out, and the comparator's P!=Q# answer gates the next stage.
module comparator_cascade #(
    parameter int NBYTES     = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [8*NBYTES-1:0]   a_i,
    input  logic [8*NBYTES-1:0]   b_i,
    output logic [7:0]            cmp_a_o,
    output logic [7:0]            cmp_b_o,
    output logic                  cmp_ng_o,
    input  logic                  cmp_neq_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  neq_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

    logic [1:0]          state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic                acc_q, acc_d;
    logic [8*NBYTES-1:0] a_q, a_d, b_q, b_d;
    logic [7:0]          cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
    logic                cmp_ng_q, cmp_ng_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                neq_q, neq_d;

    logic                neq_s;
    logic [2:0]          idx_inc_s;
    logic [7:0]          byte_a_s, byte_b_s;

    // Anything other than a clean 0 from the comparator counts as unequal.
    always_comb begin
        if (cmp_neq_i == 1'b0) begin
            neq_s = 1'b0;
        end else begin
            neq_s = 1'b1;
        end
    end

    // Next-state logic: the cmp_* outputs are precomputed for the coming stage.
    always_comb begin
        idx_inc_s = idx_q + 3'd1;
        byte_a_s  = 8'(a_q >> {idx_inc_s, 3'b000});
        byte_b_s  = 8'(b_q >> {idx_inc_s, 3'b000});

        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        cmp_a_d  = cmp_a_q;
        cmp_b_d  = cmp_b_q;
        cmp_ng_d = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        neq_d    = neq_q;

        case (state_q)
            S_RUN: begin
                acc_d = neq_s;
                if ((idx_q == LAST_IDX) || (EARLY_EXIT && neq_s)) begin
                    state_d = S_DONE;
                    neq_d   = neq_s;
                    done_d  = 1'b1;
                end else begin
                    idx_d    = idx_inc_s;
                    cmp_a_d  = byte_a_s;
                    cmp_b_d  = byte_b_s;
                    cmp_ng_d = neq_s;
                    busy_d   = 1'b1;
                end
            end
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    a_d      = a_i;
                    b_d      = b_i;
                    idx_d    = 3'd0;
                    acc_d    = 1'b0;
                    cmp_a_d  = a_i[7:0];
                    cmp_b_d  = b_i[7:0];
                    cmp_ng_d = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            acc_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cmp_a_q  <= 8'h00;
            cmp_b_q  <= 8'h00;
            cmp_ng_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            neq_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cmp_a_q  <= cmp_a_d;
            cmp_b_q  <= cmp_b_d;
            cmp_ng_q <= cmp_ng_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            neq_q    <= neq_d;
        end
    end

    assign cmp_a_o  = cmp_a_q;
    assign cmp_b_o  = cmp_b_q;
    assign cmp_ng_o = cmp_ng_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign neq_o    = neq_q;

endmodule

// File: tb/tb_comparator_cascade.sv
// Bench for comparator_cascade: one early-exit and one full-run instance share
// stimulus, each wired to its own behavioural 74x688.
`timescale 1ns/1ps
module tb_comparator_cascade;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] a, b;

    logic [7:0]  ca_e, cb_e, ca_f, cb_f;
    logic        ng_e, ng_f, neq688_e, neq688_f;
    logic        busy_e, done_e, neq_e, busy_f, done_f, neq_f;

    int checks   = 0;
    int failures = 0;
    logic prev_e, prev_f;

    always #5 clk = ~clk;

    assign #1 neq688_e = ng_e ? 1'b1 : (ca_e != cb_e);
    assign #1 neq688_f = ng_f ? 1'b1 : (ca_f != cb_f);

    comparator_cascade #(.NBYTES(4), .EARLY_EXIT(1'b1)) dut_e (
        .clk_i(clk), .reset_i(reset), .start_i(start), .a_i(a), .b_i(b),
        .cmp_a_o(ca_e), .cmp_b_o(cb_e), .cmp_ng_o(ng_e), .cmp_neq_i(neq688_e),
        .busy_o(busy_e), .done_o(done_e), .neq_o(neq_e)
    );

    comparator_cascade #(.NBYTES(4), .EARLY_EXIT(1'b0)) dut_f (
        .clk_i(clk), .reset_i(reset), .start_i(start), .a_i(a), .b_i(b),
        .cmp_a_o(ca_f), .cmp_b_o(cb_f), .cmp_ng_o(ng_f), .cmp_neq_i(neq688_f),
        .busy_o(busy_f), .done_o(done_f), .neq_o(neq_f)
    );

    // Observation vector: {busy, done, cmp_ng, neq, cmp_a, cmp_b}
    localparam logic [19:0] RESET_VEC = {4'b0011, 8'h00, 8'h00};

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (busy,done,ng,neq,a,b)", tag, obs, exp_v);
        end
    endtask

    // Expected outputs in cycle j (1 = first cycle after the accepting edge).
    function automatic logic [19:0] exp_vec(input int j, input int runs, input int k,
                                            input logic [31:0] av, input logic [31:0] bv,
                                            input logic prevn, input logic newn);
        int          s;
        logic [31:0] sa, sb;
        logic        bz, dn, ng, nq;
        s  = (j <= runs) ? j - 1 : runs - 1;
        sa = av >> (8 * s);
        sb = bv >> (8 * s);
        if (j <= runs) begin
            bz = 1'b1; dn = 1'b0; ng = (s > k); nq = prevn;
        end else if (j == runs + 1) begin
            bz = 1'b0; dn = 1'b1; ng = 1'b1; nq = newn;
        end else begin
            bz = 1'b0; dn = 1'b0; ng = 1'b1; nq = newn;
        end
        return {bz, dn, ng, nq, sa[7:0], sb[7:0]};
    endfunction

    // One operation; caller is at a negedge. hold keeps start high throughout.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit hold);
        int k;
        int runs_e;
        logic newn;
        k = 4;
        for (int i = 3; i >= 0; i--) begin
            if (((av >> (8 * i)) & 32'hFF) != ((bv >> (8 * i)) & 32'hFF)) k = i;
        end
        runs_e = (k < 4) ? k + 1 : 4;
        newn   = (av != bv);
        start  = 1'b1;
        a      = av;
        b      = bv;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (j < 5) begin
                a = $urandom;
                b = $urandom;
            end
            chk("early", {busy_e, done_e, ng_e, neq_e, ca_e, cb_e},
                exp_vec(j, runs_e, k, av, bv, prev_e, newn));
            chk("full", {busy_f, done_f, ng_f, neq_f, ca_f, cb_f},
                exp_vec(j, 4, k, av, bv, prev_f, newn));
        end
        prev_e = newn;
        prev_f = newn;
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        prev_e = 1'b1;
        prev_f = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_e", {busy_e, done_e, ng_e, neq_e, ca_e, cb_e}, RESET_VEC);
            chk("idle_f", {busy_f, done_f, ng_f, neq_f, ca_f, cb_f}, RESET_VEC);
        end

        // Equal operands, then mismatch at byte 2
        run_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        run_op(32'h12345678, 32'h12355678, 1'b0);
        run_op(32'h00000001, 32'h00000000, 1'b0);
        run_op(32'h80000000, 32'h00000000, 1'b0);

        // Back-to-back with start held high
        run_op(32'hA5A55A5A, 32'hA5A55A5A, 1'b1);
        run_op(32'h0F1E2D3C, 32'h0F1E2D3C, 1'b1);
        run_op(32'hA5A55A5A, 32'hA5A55A5A, 1'b1);
        run_op(32'h0F1E2D3C, 32'h0F1E2D3C, 1'b0);

        // Reset during the second RUN cycle aborts without a done pulse
        start = 1'b1;
        a     = 32'h11223344;
        b     = 32'h99223344;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_e", {busy_e, done_e, ng_e, neq_e, ca_e, cb_e}, RESET_VEC);
        chk("abort_f", {busy_f, done_f, ng_f, neq_f, ca_f, cb_f}, RESET_VEC);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_abort_e", {busy_e, done_e, ng_e, neq_e, ca_e, cb_e}, RESET_VEC);
            chk("post_abort_f", {busy_f, done_f, ng_f, neq_f, ca_f, cb_f}, RESET_VEC);
        end
        prev_e = 1'b1;
        prev_f = 1'b1;

        // Random operand pairs, biased towards equal and single-bit differences
        for (int n = 0; n < 10000; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0: rb = $urandom;
                1: rb = ra;
                default: rb = ra ^ (32'h1 << $urandom_range(0, 31));
            endcase
            run_op(ra, rb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comparator_cascade.md
COMPARATOR_CASCADE -- requirements
Module: comparator_cascade

Interface
REQ-001 Parameter NBYTES, default 4, meaning number of byte stages compared per operation (range 1..8).
REQ-002 Parameter EARLY_EXIT, default 1, meaning terminate on first unequal byte when 1, always run all NBYTES stages when 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-005 start  input  1  request a comparison; sampled only when idle (REQ-012).
REQ-006 a  input  8*NBYTES  first operand, captured on accepted start.
REQ-007 b  input  8*NBYTES  second operand, captured on accepted start.
REQ-008 cmp_a, cmp_b  output  8 each  registered byte presented to external 74x688 P/Q inputs.
REQ-009 cmp_ng  output  1  registered active-low gate to external 74x688 (G#).
REQ-010 cmp_neq  input  1  external 74x688 P≠Q# output (1 = unequal or gate disabled), combinational from cmp_a/cmp_b/cmp_ng.
REQ-011 busy, done, neq  output  1 each  busy = stages in progress; done = one-cycle completion pulse; neq = final result (1 = unequal).

Function
REQ-012 States IDLE, RUN, DONE; start is accepted in IDLE or DONE, ignored in RUN.
REQ-013 Accepted start: latch a, b; stage index idx=0; accumulator acc=0; next state RUN.
REQ-014 In RUN, stage idx drives cmp_a=a_latched[8*idx+7:8*idx], cmp_b=b_latched[8*idx+7:8*idx], cmp_ng=acc (stage 0 gate 0); byte 0 (LSB) first.
REQ-015 Each RUN cycle, acc <= cmp_neq sampled at the rising edge; this emulates cascading neq into the next stage's gate.
REQ-016 RUN -> DONE when idx=NBYTES-1, or when EARLY_EXIT=1 and sampled cmp_neq=1; otherwise idx increments by 1.
REQ-017 On RUN->DONE edge: neq <= sampled cmp_neq; done=1 for exactly the DONE cycle; busy=0 in DONE.
REQ-018 DONE -> IDLE next cycle unless start is high, in which case DONE -> RUN (back-to-back, no idle bubble).
REQ-019 neq holds its value from completion until the next completion or reset; not altered by start.
REQ-020 Latency: start at edge N, all bytes equal -> done high in cycle N+NBYTES+1; with EARLY_EXIT=1 and first mismatch at byte k -> done in cycle N+k+2.
REQ-021 busy=1 exactly in RUN cycles.
REQ-022 Outside RUN: cmp_ng=1, cmp_a and cmp_b hold last value.
REQ-023 Changes to a/b while not accepting start have no effect on the running comparison.
REQ-024 With EARLY_EXIT=0 a mismatch at byte k forces cmp_ng=1 for stages k+1..NBYTES-1, final neq=1.
REQ-025 cmp_neq X/Z when sampled in RUN is treated as 1 (unequal) by acc.

Reset
REQ-026 reset=1 at a rising edge: state IDLE, idx=0, acc=0, cmp_a=0x00, cmp_b=0x00, cmp_ng=1, busy=0, done=0, neq=1.
REQ-027 reset has priority over start and over any RUN/DONE transition, including mid-operation; no done pulse is produced for an aborted comparison.

Verification (NBYTES=4, bench models 74x688 combinationally with 1 ns delay)
REQ-028 Reset then idle 5 cycles -> cmp_ng=1, busy=0, done=0, neq=1, cmp_a=cmp_b=0x00 throughout.
REQ-029 start 1 cycle, a=b=0xDEADBEEF -> cmp_a sequence EF,BE,AD,DE with cmp_ng=0 each stage; done 5 cycles after start edge; neq=0.
REQ-030 EARLY_EXIT=1, a=0x12345678, b=0x12355678 -> mismatch at byte 2; busy 3 cycles; done 4 cycles after start; neq=1.
REQ-031 EARLY_EXIT=0, same operands -> 4 RUN cycles, cmp_ng=1 on byte 3, done 5 cycles after start, neq=1.
REQ-032 start held high continuously with a=b alternating per done -> back-to-back operations every 5 cycles, start ignored during RUN, each neq correct.
REQ-033 reset asserted in 2nd RUN cycle -> next cycle all outputs at REQ-026 values, no done pulse; exhaustive random 10,000 operand pairs match a!=b reference with OK/FAIL report.
